ram_wb_slave: RTL and testbench
===============================

RAM_WB_SLAVE -- requirements
Module: ram_wb_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte base of the 16 KiB RAM window (bits [13:0] ignored).
REQ-002 SHALL have parameter RAM_AW, default 12, RAM word-address width.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; the clock and reset ports are named as the codebase does.
REQ-004 clk_i  input  1  clock; all state on rising edge.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 wb_cyc_i, wb_stb_i, wb_we_i  input  1 each  Wishbone B3 cycle, strobe, write enable.
REQ-007 wb_adr_i  input  32  byte address; wb_sel_i  input  4  byte lanes; wb_dat_i  input  32  write data.
REQ-008 wb_cti_i  input  3  cycle type (000 classic, 010 incrementing, 111 end); wb_bte_i  input  2  burst type.
REQ-009 wb_dat_o  output  32  read data; wb_ack_o  output  1  ack; wb_err_o  output  1  error.
REQ-010 ram_we_o  output  1; ram_adr_o  output  RAM_AW; ram_be_o  output  4; ram_dat_o  output  32; ram_dat_i  input  32 (RAM q, registered, valid one cycle after address).

Function
REQ-011 In-range SHALL mean wb_adr_i[31:14]==BASE_ADDR[31:14]; word address is wb_adr_i[13:2].
REQ-012 FSM states SHALL be IDLE, ACK, BURST, ERR.
REQ-013 IDLE: on cyc&stb in-range with cti!=010 -> ACK; with cti==010 and bte==00 -> BURST; out-of-range, or cti==010 with bte!=00 -> ERR.
REQ-014 IDLE: ram_adr_o SHALL be wb_adr_i[13:2] combinationally; ram_we_o=cyc&stb&we&in-range&(bte legal), ram_be_o=wb_sel_i, ram_dat_o=wb_dat_i.
REQ-015 ACK: wb_ack_o=1 for exactly one cycle, then IDLE unconditionally (classic: one idle cycle between transfers).
REQ-016 Read latency SHALL be 1 wait state: ack in cycle after strobe sampled; wb_dat_o=ram_dat_i whenever ack is high.
REQ-017 BURST: internal counter holds next word address (first beat address+1 on entry); wb_ack_o=1 every cycle stb is high.
REQ-018 BURST: ram_adr_o = counter when stb high and ack accepted, giving one ack per cycle with no bubbles; counter increments per accepted beat, wraps modulo 2^RAM_AW.
REQ-019 BURST write beats: ram_we_o=stb&we with current beat's sel/data at counter-1 address consistently (write address = beat address presented by master).
REQ-020 BURST exits to IDLE after acked beat with cti==111, or immediately if cyc_i drops; no RAM write after cyc_i low.
REQ-021 BURST: stb low with cyc high SHALL pause (no ack, no increment, no write).
REQ-022 ERR: wb_err_o=1 one cycle, wb_ack_o=0, no RAM write, then IDLE.
REQ-023 wb_ack_o and wb_err_o SHALL never be high together; neither high when cyc_i low.
REQ-024 cyc_i dropping in ACK or ERR SHALL still return to IDLE next cycle, suppressing the pending ack/err.

Reset
REQ-025 rst_i high SHALL force state IDLE, counter 0, wb_ack_o=0, wb_err_o=0, ram_we_o=0 immediately (asynchronous).
REQ-026 Reset mid-burst SHALL abort it; first cycle after release accepts a new transfer.

Structure
REQ-027 Package ram_wb_pkg SHALL hold the FSM state enum and CTI/BTE code constants.
REQ-028 No sub-module; RAM is instantiated beside this block at the parent level.

Verification
REQ-029 Classic write 0x00000010, sel 0011, data 0xDEADBEEF -> ram_we_o one cycle at word 4, ack next cycle; readback 0x0000BEEF over initial 0.
REQ-030 Classic read word 0 -> ack after 1 wait, wb_dat_o=0x3C01A000.
REQ-031 Incrementing read burst 4 beats from 0x0, last cti=111 -> 4 consecutive acks, data 3C01A000, AC200004, 8C220002-region words as loaded, then IDLE.
REQ-032 Burst write starting word 4094, 4 beats -> writes at 4094, 4095, 0, 1 (wrap).
REQ-033 Address 0x00010000 with BASE 0 -> err one cycle, no ack, ram_we_o never high; bte=01 burst -> err.
REQ-034 rst_i asserted during beat 2 of a burst -> ack/err 0 at once, no further writes, new classic read after release acks normally.

Source files
------------

// File: rtl/ram_wb_pkg.sv
// Shared types and Wishbone B3 cycle/burst type codes for the RAM slave.
package ram_wb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        BURST,
        ERR
    } wb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/ram_wb_slave.sv
// Wishbone B3 slave fronting a 16 KiB synchronous RAM: classic cycles with one
// wait state, linear incrementing bursts at one beat per cycle, error on bad access.
module ram_wb_slave
    import ram_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          RAM_AW    = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [2:0]        wb_cti_i,
    input  logic [1:0]        wb_bte_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              ram_we_o,
    output logic [RAM_AW-1:0] ram_adr_o,
    output logic [3:0]        ram_be_o,
    output logic [31:0]       ram_dat_o,
    input  logic [31:0]       ram_dat_i
);

    localparam logic [RAM_AW-1:0] ADR_ONE = {{(RAM_AW-1){1'b0}}, 1'b1};

    wb_state_e         state;
    logic [RAM_AW-1:0] cnt;
    logic              req;
    logic              in_range;
    logic              is_incr;
    logic              bte_ok;
    logic [RAM_AW-1:0] word_adr;
    logic              unused_adr;

    assign req        = wb_cyc_i & wb_stb_i;
    assign in_range   = (wb_adr_i[31:14] == BASE_ADDR[31:14]);
    assign word_adr   = wb_adr_i[RAM_AW+1:2];
    assign is_incr    = (wb_cti_i == CTI_INCR);
    assign bte_ok     = !is_incr || (wb_bte_i == BTE_LINEAR);
    assign unused_adr = ^wb_adr_i[1:0];

    assign ram_be_o  = wb_sel_i;
    assign ram_dat_o = wb_dat_i;
    assign wb_dat_o  = ram_dat_i;

    // Ack/err are gated by cyc so a master abandoning the cycle never sees a late response.
    assign wb_ack_o = wb_cyc_i & ((state == ACK) | ((state == BURST) & wb_stb_i));
    assign wb_err_o = wb_cyc_i & (state == ERR);

    // In a burst, cnt runs one word ahead of the beat being acked so read data is
    // ready every cycle; writes and paused reads therefore target cnt-1.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        ram_adr_o = word_adr;
        ram_we_o  = 1'b0;
        case (state)
            IDLE: begin
                ram_adr_o = word_adr;
                ram_we_o  = req & wb_we_i & in_range & bte_ok;
            end
            BURST: begin
                ram_adr_o = (req && !wb_we_i) ? cnt : (cnt - ADR_ONE);
                ram_we_o  = req & wb_we_i;
            end
            default: ;
        endcase
        if (rst_i) begin
            ram_we_o = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (!in_range || !bte_ok) begin
                            state <= ERR;
                        end else if (is_incr) begin
                            state <= BURST;
                            cnt   <= word_adr + ADR_ONE;
                        end else begin
                            state <= ACK;
                        end
                    end
                end
                ACK, ERR: state <= IDLE;
                BURST: begin
                    if (!wb_cyc_i) begin
                        state <= IDLE;
                    end else if (wb_stb_i) begin
                        cnt <= cnt + ADR_ONE;
                        if (wb_cti_i == CTI_END) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_wb_slave.sv
// Bench for ram_wb_slave: directed Wishbone master, behavioural RAM, and a
// scoreboard monitor that matches every ack/err against queued expectations.
module tb_ram_wb_slave;

    typedef struct {
        bit          is_err;
        bit          chk;
        logic [31:0] data;
        string       name;
    } exp_t;

    typedef struct {
        logic [11:0] adr;
        logic [3:0]  be;
        logic [31:0] dat;
    } wr_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic [2:0]  wb_cti_i = '0;
    logic [1:0]  wb_bte_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic        ram_we_o;
    logic [11:0] ram_adr_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_dat_o;
    logic [31:0] ram_dat_i;

    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    wr_t         wr_log[$];
    wr_t         exp_wr[$];
    logic [31:0] exp_rd[4];
    logic [31:0] wr_dat[4];

    logic [31:0] mem [0:4095];
    bit          loaded = 1'b0;
    bit          prev_we = 1'b0;
    wr_t         prev_wr;

    ram_wb_slave #(.BASE_ADDR(32'h0000_0000), .RAM_AW(12)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
        .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .ram_we_o(ram_we_o), .ram_adr_o(ram_adr_o), .ram_be_o(ram_be_o),
        .ram_dat_o(ram_dat_o), .ram_dat_i(ram_dat_i)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous RAM with byte enables; q is registered, one cycle after address.
    always @(posedge clk_i) begin
        if (!loaded) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h3C01A000;
            mem[1] <= 32'hAC200004;
            mem[2] <= 32'h8C220002;
            mem[3] <= 32'h00431020;
            loaded <= 1'b1;
        end else if (ram_we_o) begin
            for (int b = 0; b < 4; b++)
                if (ram_be_o[b]) mem[ram_adr_o][8*b +: 8] <= ram_dat_o[8*b +: 8];
        end
        ram_dat_i <= mem[ram_adr_o];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Monitor: scoreboard for responses plus a log of distinct RAM writes.
    always @(negedge clk_i) begin
        exp_t e;
        wr_t  w;
        if (wb_ack_o || wb_err_o) begin
            check("ack_err_excl", 32'(wb_ack_o & wb_err_o), 32'h0);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_resp: got ack=%0b err=%0b expected none", wb_ack_o, wb_err_o);
            end else begin
                checks--;
                e = exp_q.pop_front();
                check({e.name, "_kind"}, 32'(wb_err_o), 32'(e.is_err));
                if (e.chk) check({e.name, "_data"}, wb_dat_o, e.data);
            end
        end
        w = '{adr: ram_adr_o, be: ram_be_o, dat: ram_dat_o};
        if (ram_we_o && !(prev_we && w == prev_wr)) wr_log.push_back(w);
        prev_we = ram_we_o;
        prev_wr = w;
    end

    task automatic check_log(input string name);
        check({name, "_nwr"}, 32'(wr_log.size()), 32'(exp_wr.size()));
        if (wr_log.size() == exp_wr.size()) begin
            for (int i = 0; i < wr_log.size(); i++) begin
                check({name, "_wadr"}, 32'(wr_log[i].adr), 32'(exp_wr[i].adr));
                check({name, "_wbe"},  32'(wr_log[i].be),  32'(exp_wr[i].be));
                check({name, "_wdat"}, wr_log[i].dat, exp_wr[i].dat);
            end
        end
        wr_log.delete();
        exp_wr.delete();
    endtask

    task automatic idle_bus();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_cti_i = 3'b000; wb_bte_i = 2'b00;
    endtask

    task automatic classic(input string name, input logic we, input logic [31:0] adr,
                           input logic [3:0] sel, input logic [31:0] dat,
                           input logic [2:0] cti, input logic [1:0] bte,
                           input bit exp_err, input logic [31:0] exp_data);
        int n;
        bit got;
        exp_q.push_back('{is_err: exp_err, chk: !we && !exp_err, data: exp_data, name: name});
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
        wb_cti_i = cti; wb_bte_i = bte;
        n = 0; got = 1'b0;
        while (!got && n < 8) begin
            @(negedge clk_i);
            n++;
            got = wb_ack_o | wb_err_o;
        end
        if (!got) fail_now(name);
        else check({name, "_latency"}, 32'(n), 32'd2);
        @(posedge clk_i); #1;
        idle_bus();
    endtask

    task automatic burst(input string name, input logic we, input int start,
                         input int n, input int pause_at, input int exp_cycles);
        int  i, cyc_cnt, shown;
        bit  paused;
        logic [31:0] w;
        i = 0; cyc_cnt = 0; shown = -1; paused = 1'b0;
        @(posedge clk_i); #1;
        while (i < n && cyc_cnt < 40) begin
            if (i == pause_at && !paused) begin
                paused = 1'b1;
                wb_cyc_i = 1'b1; wb_stb_i = 1'b0;
            end else begin
                if (shown != i) begin
                    exp_q.push_back('{is_err: 1'b0, chk: !we, data: exp_rd[i], name: name});
                    shown = i;
                end
                w = 32'((start + i) % 4096);
                wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
                wb_adr_i = w << 2; wb_sel_i = 4'hF; wb_dat_i = wr_dat[i];
                wb_cti_i = (i == n - 1) ? 3'b111 : 3'b010; wb_bte_i = 2'b00;
            end
            @(negedge clk_i);
            cyc_cnt++;
            if (wb_ack_o) i++;
            @(posedge clk_i); #1;
        end
        idle_bus();
        if (i < n) fail_now(name);
        else check({name, "_cycles"}, 32'(cyc_cnt), 32'(exp_cycles));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_dat = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

        // Reset holds write strobe low even with a write request on the bus.
        repeat (2) @(posedge clk_i);
        #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'hF;
        #1;
        check("rst_ack", 32'(wb_ack_o), 32'h0);
        check("rst_err", 32'(wb_err_o), 32'h0);
        check("rst_we",  32'(ram_we_o), 32'h0);
        idle_bus();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        wr_log.delete();

        // Classic partial write then readback over zero-initialised word.
        classic("wr4", 1'b1, 32'h0000_0010, 4'b0011, 32'hDEADBEEF, 3'b000, 2'b00, 1'b0, 32'h0);
        exp_wr.push_back('{adr: 12'd4, be: 4'b0011, dat: 32'hDEADBEEF});
        check_log("wr4");
        classic("rd4", 1'b0, 32'h0000_0010, 4'hF, 32'h0, 3'b000, 2'b00, 1'b0, 32'h0000BEEF);
        classic("rd0", 1'b0, 32'h0000_0000, 4'hF, 32'h0, 3'b000, 2'b00, 1'b0, 32'h3C01A000);

        // Incrementing read burst, back-to-back then with a one-cycle stb pause.
        exp_rd = '{32'h3C01A000, 32'hAC200004, 32'h8C220002, 32'h00431020};
        burst("brd", 1'b0, 0, 4, -1, 5);
        burst("brd_pause", 1'b0, 0, 4, 2, 6);

        // Write burst wrapping the top of the word space.
        burst("bwr", 1'b1, 4094, 4, -1, 5);
        exp_wr.push_back('{adr: 12'd4094, be: 4'hF, dat: 32'h11111111});
        exp_wr.push_back('{adr: 12'd4095, be: 4'hF, dat: 32'h22222222});
        exp_wr.push_back('{adr: 12'd0,    be: 4'hF, dat: 32'h33333333});
        exp_wr.push_back('{adr: 12'd1,    be: 4'hF, dat: 32'h44444444});
        check_log("bwr");
        exp_rd = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        burst("brd_wrap", 1'b0, 4094, 4, -1, 5);

        // Error cases: out of window, and an illegal burst type; no writes allowed.
        classic("err_rd", 1'b0, 32'h0001_0000, 4'hF, 32'h0, 3'b000, 2'b00, 1'b1, 32'h0);
        classic("err_wr", 1'b1, 32'h0001_0000, 4'hF, 32'hCAFEF00D, 3'b000, 2'b00, 1'b1, 32'h0);
        classic("err_bte", 1'b1, 32'h0000_0020, 4'hF, 32'hCAFEF00D, 3'b010, 2'b01, 1'b1, 32'h0);
        check_log("err");

        // Master drops cyc during the ack cycle: the ack is withheld.
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h0000_0010;
        @(posedge clk_i); #1;
        idle_bus();
        @(negedge clk_i);
        check("cyc_drop_ack", 32'(wb_ack_o), 32'h0);
        classic("rd_after_drop", 1'b0, 32'h0000_0010, 4'hF, 32'h0, 3'b000, 2'b00, 1'b0, 32'h0000BEEF);

        // Reset during beat 2 of a write burst aborts it immediately.
        exp_q.push_back('{is_err: 1'b0, chk: 1'b0, data: 32'h0, name: "rst_b0"});
        exp_q.push_back('{is_err: 1'b0, chk: 1'b0, data: 32'h0, name: "rst_b1"});
        @(posedge clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 4'hF;
        wb_cti_i = 3'b010; wb_bte_i = 2'b00;
        wb_adr_i = 32'h0000_0020; wb_dat_i = 32'hA0A0A0A0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        wb_adr_i = 32'h0000_0024; wb_dat_i = 32'hA1A1A1A1;
        @(posedge clk_i); #1;
        wb_adr_i = 32'h0000_0028; wb_dat_i = 32'hA2A2A2A2;
        #2;
        rst_i = 1'b1;
        #1;
        check("mid_rst_ack", 32'(wb_ack_o), 32'h0);
        check("mid_rst_err", 32'(wb_err_o), 32'h0);
        check("mid_rst_we",  32'(ram_we_o), 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        idle_bus();
        rst_i = 1'b0;
        exp_wr.push_back('{adr: 12'd8, be: 4'hF, dat: 32'hA0A0A0A0});
        exp_wr.push_back('{adr: 12'd9, be: 4'hF, dat: 32'hA1A1A1A1});
        check_log("rst_burst");
        classic("rd_after_rst", 1'b0, 32'h0000_0020, 4'hF, 32'h0, 3'b000, 2'b00, 1'b0, 32'hA0A0A0A0);

        repeat (3) @(posedge clk_i);
        check("sb_drain", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
